// File: rtl/mul_pkg.sv
// Shared types for the RV32M multiply issue controller: funct3 codes, FSM states and the
// decoded operand-control struct.
package mul_pkg;

   localparam logic [2:0] Funct3Mul    = 3'b000;
   localparam logic [2:0] Funct3Mulh   = 3'b001;
   localparam logic [2:0] Funct3Mulhsu = 3'b010;
   localparam logic [2:0] Funct3Mulhu  = 3'b011;

   typedef enum logic [1:0] {
      StIdle,
      StStart,
      StWait,
      StResp
   } mul_state_e;

   typedef struct packed {
      logic signed_a;
      logic signed_b;
      logic upper;
   } mul_ctrl_t;

   // Only funct3[1:0] distinguishes the four multiply flavours.
   function automatic mul_ctrl_t decode_funct3(input logic [1:0] fn);
      mul_ctrl_t ctrl;
      unique case (fn)
         Funct3Mul[1:0]:    ctrl = '{signed_a: 1'b1, signed_b: 1'b1, upper: 1'b0};
         Funct3Mulh[1:0]:   ctrl = '{signed_a: 1'b1, signed_b: 1'b1, upper: 1'b1};
         Funct3Mulhsu[1:0]: ctrl = '{signed_a: 1'b1, signed_b: 1'b0, upper: 1'b1};
         Funct3Mulhu[1:0]:  ctrl = '{signed_a: 1'b0, signed_b: 1'b0, upper: 1'b1};
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/mul_result_cache.sv
// Single-entry cache of the last completed multiply: {funct3[1:0], rs1, rs2, result} plus a
// valid bit. Only present in builds that define MUL_RESULT_CACHE_EN.
module mul_result_cache
   import mul_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  lookup_fn_i,
   input  logic [31:0] lookup_a_i,
   input  logic [31:0] lookup_b_i,
   output logic        hit_o,
   output logic [31:0] hit_data_o,
   input  logic        wr_en_i,
   input  logic [1:0]  wr_fn_i,
   input  logic [31:0] wr_a_i,
   input  logic [31:0] wr_b_i,
   input  logic [31:0] wr_data_i
);

   logic        valid_q;
   logic [1:0]  fn_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         fn_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
      end else if (wr_en_i) begin
         valid_q <= 1'b1;
         fn_q    <= wr_fn_i;
         a_q     <= wr_a_i;
         b_q     <= wr_b_i;
         data_q  <= wr_data_i;
      end
   end

   always_comb begin
      hit_o      = valid_q && (lookup_fn_i == fn_q) && (lookup_a_i == a_q) && (lookup_b_i == b_q);
      hit_data_o = data_q;
   end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller between the core and an external multi-cycle multiplier; one request in flight.
// Build option: MUL_RESULT_CACHE_EN adds a last-result cache that bypasses the multiplier.
module mul_issue_ctrl
   import mul_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic [4:0]  rd_addr_i,
   output logic        mult_en_o,
   output logic [31:0] op_A_o,
   output logic [31:0] op_B_o,
   output logic        signed_A_o,
   output logic        signed_B_o,
   output logic        upper_o,
   input  logic [31:0] mult_result_i,
   input  logic        mult_done_i,
   output logic        wb_valid_o,
   input  logic        wb_ready_i,
   output logic [31:0] wb_data_o,
   output logic [4:0]  wb_rd_o
);

   mul_state_e  state_q, state_d;
   logic [31:0] op_a_q;
   logic [31:0] op_b_q;
   mul_ctrl_t   ctrl_q;
   logic [4:0]  rd_q;
   logic [31:0] result_q, result_d;
   logic        accept;
   logic        unused_funct3_bit;

   assign unused_funct3_bit = funct3_i[2];

`ifdef MUL_RESULT_CACHE_EN
   logic [1:0]  fn_q;
   logic        cache_hit;
   logic [31:0] cache_data;

   mul_result_cache u_cache (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .lookup_fn_i (funct3_i[1:0]),
      .lookup_a_i  (rs1_i),
      .lookup_b_i  (rs2_i),
      .hit_o       (cache_hit),
      .hit_data_o  (cache_data),
      .wr_en_i     ((state_q == StWait) && mult_done_i),
      .wr_fn_i     (fn_q),
      .wr_a_i      (op_a_q),
      .wr_b_i      (op_b_q),
      .wr_data_i   (mult_result_i)
   );
`endif

   // Gated with rst_i so the block never advertises readiness while held in reset.
   assign req_ready_o = (state_q == StIdle) && !rst_i;
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StStart;
`ifdef MUL_RESULT_CACHE_EN
               if (cache_hit) begin
                  state_d  = StResp;
                  result_d = cache_data;
               end
`endif
            end
         end
         StStart: state_d = StWait;
         StWait: begin
            if (mult_done_i) begin
               result_d = mult_result_i;
               state_d  = StResp;
            end
         end
         StResp: begin
            if (wb_ready_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         op_a_q   <= '0;
         op_b_q   <= '0;
         ctrl_q   <= '0;
         rd_q     <= '0;
         result_q <= '0;
`ifdef MUL_RESULT_CACHE_EN
         fn_q     <= '0;
`endif
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         if (accept) begin
            op_a_q <= rs1_i;
            op_b_q <= rs2_i;
            rd_q   <= rd_addr_i;
            ctrl_q <= decode_funct3(funct3_i[1:0]);
`ifdef MUL_RESULT_CACHE_EN
            fn_q   <= funct3_i[1:0];
`endif
         end
      end
   end

   always_comb begin
      mult_en_o  = (state_q == StStart);
      wb_valid_o = (state_q == StResp);
      op_A_o     = op_a_q;
      op_B_o     = op_b_q;
      signed_A_o = ctrl_q.signed_a;
      signed_B_o = ctrl_q.signed_b;
      upper_o    = ctrl_q.upper;
      wb_data_o  = result_q;
      wb_rd_o    = rd_q;
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with an 8-cycle behavioural multiplier.
// Define MUL_RESULT_CACHE_EN for both DUT and bench to exercise the cache build.
module tb_mul_issue_ctrl;

   localparam int MulLat = 8;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_ready_o;
   logic [2:0]  funct3_i = '0;
   logic [31:0] rs1_i = '0;
   logic [31:0] rs2_i = '0;
   logic [4:0]  rd_addr_i = '0;
   logic        mult_en_o;
   logic [31:0] op_A_o;
   logic [31:0] op_B_o;
   logic        signed_A_o;
   logic        signed_B_o;
   logic        upper_o;
   logic [31:0] mult_result_i;
   logic        mult_done_i;
   logic        wb_valid_o;
   logic        wb_ready_i = 1'b0;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_rd_o;

   int n_checks = 0;
   int n_pass   = 0;
   logic [36:0] sb_q[$];

   // Reference-side cache image: last completed request
   bit          c_valid = 0;
   logic [1:0]  c_fn;
   logic [31:0] c_a, c_b;

   always #5 clk_i = ~clk_i;

   mul_issue_ctrl dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .funct3_i      (funct3_i),
      .rs1_i         (rs1_i),
      .rs2_i         (rs2_i),
      .rd_addr_i     (rd_addr_i),
      .mult_en_o     (mult_en_o),
      .op_A_o        (op_A_o),
      .op_B_o        (op_B_o),
      .signed_A_o    (signed_A_o),
      .signed_B_o    (signed_B_o),
      .upper_o       (upper_o),
      .mult_result_i (mult_result_i),
      .mult_done_i   (mult_done_i),
      .wb_valid_o    (wb_valid_o),
      .wb_ready_i    (wb_ready_i),
      .wb_data_o     (wb_data_o),
      .wb_rd_o       (wb_rd_o)
   );

   // Behavioural multiplier: done pulses MulLat cycles after the mult_en cycle. Outside that
   // pulse the result bus carries junk and stray done pulses appear while it is idle.
   int          m_cnt;
   logic [31:0] m_prod;
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_cnt         <= 0;
         mult_done_i   <= 1'b0;
         mult_result_i <= '0;
         m_prod        <= '0;
      end else begin
         mult_done_i   <= 1'b0;
         mult_result_i <= $urandom;
         if (mult_en_o) begin
            m_cnt  <= MulLat;
            m_prod <= hw_mul(op_A_o, op_B_o, signed_A_o, signed_B_o, upper_o);
         end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
               mult_done_i   <= 1'b1;
               mult_result_i <= m_prod;
            end
         end else if ($urandom_range(0, 5) == 0) begin
            mult_done_i <= 1'b1;
         end
      end
   end

   function automatic logic [31:0] hw_mul(input logic [31:0] a, b, input logic sa, sb, up);
      logic [63:0] ea, eb, p;
      ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
      eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
      p  = ea * eb;
      return up ? p[63:32] : p[31:0];
   endfunction

   // Reference: expected (signed_A, signed_B, upper) per funct3 flavour.
   function automatic logic [2:0] ref_ctrl(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 3'b110;
         2'b01:   return 3'b111;
         2'b10:   return 3'b101;
         default: return 3'b001;
      endcase
   endfunction

   function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a, b);
      logic [2:0] c;
      c = ref_ctrl(f3);
      return hw_mul(a, b, c[2], c[1], c[0]);
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: every writeback handshake pops the oldest expected {rd, data}.
   always @(negedge clk_i) begin
      if (!rst_i && wb_valid_o && wb_ready_i) begin
         if (sb_q.size() == 0) begin
            chk("wb_unexpected", {wb_rd_o, wb_data_o}, 37'h0);
         end else begin
            logic [36:0] e;
            e = sb_q.pop_front();
            chk("wb_data", wb_data_o, e[31:0]);
            chk("wb_rd", wb_rd_o, e[36:32]);
         end
      end
   end

   task automatic do_req(input logic [2:0] f3, input logic [31:0] a, b, input logic [4:0] rd,
                         input logic [31:0] exp_data, input int stall,
                         output int lat, output int ens);
      bit          hit, stable;
      int          k;
      logic [31:0] d;
      logic [4:0]  r;
      hit = 0;
`ifdef MUL_RESULT_CACHE_EN
      hit = c_valid && (c_fn == f3[1:0]) && (c_a == a) && (c_b == b);
`endif
      k = 0;
      while (!req_ready_o && k < 50) begin
         @(negedge clk_i);
         k++;
      end
      if (!req_ready_o) chk("req_ready_timeout", req_ready_o, 1'b1);
      sb_q.push_back({rd, exp_data});
      funct3_i    = f3;
      rs1_i       = a;
      rs2_i       = b;
      rd_addr_i   = rd;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      rs1_i       = $urandom;
      rs2_i       = $urandom;
      funct3_i    = 3'($urandom);
      rd_addr_i   = 5'($urandom);
      chk("ctrl", {signed_A_o, signed_B_o, upper_o}, ref_ctrl(f3));
      chk("ops", {op_A_o, op_B_o}, {a, b});
      ens    = 0;
      stable = 1;
      k      = 0;
      while (!wb_valid_o && k < 40) begin
         if (mult_en_o) ens++;
         if (req_ready_o || {op_A_o, op_B_o, signed_A_o, signed_B_o, upper_o} !==
             {a, b, ref_ctrl(f3)}) stable = 0;
         @(posedge clk_i);
         #1;
         k++;
      end
      lat = k + 1;
      chk("latency", lat, hit ? 1 : MulLat + 2);
      chk("mult_en_pulses", ens, hit ? 0 : 1);
      chk("op_hold", stable, 1'b1);
      d = wb_data_o;
      r = wb_rd_o;
      stable = 1;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk_i);
         #1;
         if (!wb_valid_o || req_ready_o || wb_data_o !== d || wb_rd_o !== r) stable = 0;
      end
      chk("resp_hold", stable, 1'b1);
      wb_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      wb_ready_i = 1'b0;
      chk("ready_after_hs", {req_ready_o, wb_valid_o}, 2'b10);
      if (!hit) begin
         c_valid = 1;
         c_fn    = f3[1:0];
         c_a     = a;
         c_b     = b;
      end
   endtask

   initial begin
      int          lat, ens, cnt;
      logic [31:0] corner[6];
      logic [2:0]  f3;
      logic [31:0] a, b;
      corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};

      #1;
      chk("reset_outputs", {req_ready_o, mult_en_o, wb_valid_o, signed_A_o, signed_B_o, upper_o,
                            op_A_o, op_B_o, wb_data_o, wb_rd_o}, '0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk("ready_after_reset", req_ready_o, 1'b1);

      do_req(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 0, lat, ens);
      chk("mulhu_latency", lat, 10);
      do_req(3'b000, 32'd7, 32'hFFFFFFFD, 5'd2, 32'hFFFFFFEB, 1, lat, ens);
      do_req(3'b010, 32'hFFFFFFFF, 32'd2, 5'd3, 32'hFFFFFFFF, 0, lat, ens);
      do_req(3'b001, 32'h80000000, 32'h80000000, 5'd4, 32'h40000000, 5, lat, ens);

      // Reset three cycles into WAIT: nothing may come out of the aborted request.
      @(negedge clk_i);
      funct3_i    = 3'b000;
      rs1_i       = 32'd9;
      rs2_i       = 32'd9;
      rd_addr_i   = 5'd5;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      repeat (4) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      chk("reset_mid_wait", {req_ready_o, mult_en_o, wb_valid_o, signed_A_o, signed_B_o, upper_o,
                             op_A_o, op_B_o, wb_data_o, wb_rd_o}, '0);
      c_valid = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("ready_in_reset", req_ready_o, 1'b0);
      rst_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk_i);
         #1;
         if (wb_valid_o) cnt++;
      end
      chk("no_wb_after_reset", cnt, 0);
      do_req(3'b000, 32'd3, 32'd4, 5'd6, 32'd12, 0, lat, ens);

      do_req(3'b001, 32'd5, 32'd6, 5'd7, 32'd0, 0, lat, ens);
      do_req(3'b001, 32'd5, 32'd6, 5'd8, 32'd0, 2, lat, ens);
`ifdef MUL_RESULT_CACHE_EN
      chk("cache_hit_latency", lat, 1);
      chk("cache_hit_no_en", ens, 0);
`endif
      do_req(3'b001, 32'd5, 32'd7, 5'd9, 32'd0, 0, lat, ens);
      chk("cache_miss_latency", lat, 10);

      for (int i = 0; i < 16; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 1) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         b  = ($urandom_range(0, 1) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         if (c_valid && $urandom_range(0, 2) == 0) begin
            f3 = {1'b0, c_fn};
            a  = c_a;
            b  = c_b;
         end
         do_req(f3, a, b, 5'($urandom), ref_mul(f3, a, b), $urandom_range(0, 3), lat, ens);
      end

      repeat (3) @(posedge clk_i);
      chk("scoreboard_drained", sb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL provide the following ports; clock and reset come first. The block uses one clock. Reset is asynchronous and active-high.
- clk_i  input  1  block clock
- rst_i  input  1  asynchronous, active-high reset
- req_valid_i  input  1  core multiply request valid
- req_ready_o  output  1  block can accept a request
- funct3_i  input  3  RV32M funct3; only 000 MUL, 001 MULH, 010 MULHSU and 011 MULHU are sent; bit 2 is ignored
- rs1_i  input  32  operand A
- rs2_i  input  32  operand B
- rd_addr_i  input  5  destination register tag
- mult_en_o  output  1  start pulse to the multiplier
- op_A_o  output  32  held operand A to the multiplier
- op_B_o  output  32  held operand B to the multiplier
- signed_A_o  output  1  operand A signedness
- signed_B_o  output  1  operand B signedness
- upper_o  output  1  select upper 32 product bits
- mult_result_i  input  32  multiplier result
- mult_done_i  input  1  multiplier one-cycle done pulse
- wb_valid_o  output  1  writeback data valid
- wb_ready_i  input  1  writeback sink ready
- wb_data_o  output  32  result
- wb_rd_o  output  5  destination tag

Function
REQ-002 SHALL implement FSM states IDLE, START, WAIT and RESP.
REQ-003 SHALL drive req_ready_o=1 only in IDLE.
REQ-004 SHALL treat a request as accepted when req_valid_i and req_ready_o are both high at a rising edge.
REQ-005 SHALL, on accept, register rs1, rs2, rd and decoded controls, then move to START.
REQ-006 SHALL decode funct3 to (signed_A, signed_B, upper) as follows: 000 gives (1,1,0); 001 gives (1,1,1); 010 gives (1,0,1); 011 gives (0,0,1).
REQ-007 SHALL assert mult_en_o for exactly one cycle in START, then move to WAIT.
REQ-008 SHALL hold op_A_o, op_B_o, signed_A_o, signed_B_o and upper_o stable from START through the end of WAIT.
REQ-009 SHALL, in WAIT, capture mult_result_i into the result register on the cycle mult_done_i=1, then move to RESP.
REQ-010 SHALL ignore mult_done_i in every state other than WAIT.
REQ-011 SHALL drive wb_valid_o=1 only in RESP, with wb_data_o and wb_rd_o stable while wb_valid_o=1 and wb_ready_i=0.
REQ-012 SHALL return to IDLE on the edge where wb_valid_o and wb_ready_i are both high; there is no same-cycle re-accept, so req_ready_o rises the following cycle.
REQ-013 SHALL give, for a multiplier with done N cycles after mult_en: wb_valid_o first high at accept+N+2.
REQ-014 SHALL hold at most one request in flight.

Reset
REQ-015 SHALL, on rst_i=1 at any time including mid-WAIT, immediately force the FSM to IDLE.
REQ-016 SHALL, during reset, hold req_ready_o=0, and after reset deassertion drive req_ready_o=1 from the first clock edge.
REQ-017 SHALL reset mult_en_o, wb_valid_o, signed_A_o, signed_B_o and upper_o to 0, and op_A_o, op_B_o, wb_data_o and wb_rd_o to 0.
REQ-018 SHALL discard any in-flight result on reset; the multiplier shares rst_i.

Configuration
REQ-019 SHALL support the macro MUL_RESULT_CACHE_EN.
REQ-020 SHALL, when MUL_RESULT_CACHE_EN is defined:
- keep the last completed {funct3[1:0], rs1, rs2, result} plus a valid bit;
- on an accepted request whose funct3[1:0], rs1 and rs2 all match while valid=1, skip START and WAIT and go directly to RESP with the cached result, giving wb_valid_o at accept+1;
- on a miss, follow the normal path and overwrite the cache on done.
REQ-021 SHALL clear the cache valid bit on reset.
REQ-022 SHALL, when MUL_RESULT_CACHE_EN is undefined, omit all cache logic and always take the START/WAIT path.

Structure
REQ-023 SHALL place the following in shared package mul_pkg:
- funct3 encoding constants (MUL, MULH, MULHSU, MULHU);
- the FSM state typedef;
- a decoded-control struct {signed_A, signed_B, upper}.
REQ-024 SHALL implement the cache as sub-module mul_result_cache, instantiated only under MUL_RESULT_CACHE_EN.

Verification
REQ-025 SHALL be verified with a behavioural 8-cycle multiplier model against the following directed scenarios:
- MULHU with rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> wb_data_o=0xFFFFFFFE and controls (0,0,1); wb_valid_o at accept+10.
- MUL with rs1=7, rs2=0xFFFFFFFD -> wb_data_o=0xFFFFFFEB and controls (1,1,0).
- MULHSU with rs1=0xFFFFFFFF, rs2=2 -> wb_data_o=0xFFFFFFFF; MULH with rs1=0x80000000, rs2=0x80000000 -> wb_data_o=0x40000000.
- wb_ready_i held low 5 cycles in RESP -> wb_valid_o, wb_data_o and wb_rd_o stable; req_ready_o stays 0 until the handshake cycle, then goes to 1.
- rst_i pulsed 3 cycles into WAIT -> all outputs 0 immediately and no wb_valid_o; a fresh MUL 3x4 afterwards -> wb_data_o=12.
- With MUL_RESULT_CACHE_EN: MULH 5x6 repeated back-to-back -> the second response arrives at accept+1 with no mult_en_o; changing rs2 to 7 -> a normal 8-cycle path.
